display_scan_mux: RTL and testbench

Time-multiplexed scan controller for the four-digit 7-segment display. It holds a 16-bit, four-nibble display word and steps through the digits at a programmable rate. Each step it presents one 4-bit digit code plus a 2-bit digit select to the downstream hex-to-7-segment decoder. In that decoder, code 4'hF means blank and select 2'b00 means anode 0 (rightmost). New data is double-buffered and committed only at frame boundaries, so the display never tears.

---
 rtl/display_scan_mux.sv | 116 +++++++++++
 tb/tb_display_scan_mux.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_mux.sv
// -----------------------------------------------------------------------------
// display_scan_mux
//
// Time-multiplexed scan controller for a four-digit 7-segment display.
// A 16-bit display word (four nibbles, digit 0 rightmost) is scanned one digit
// at a time. Each digit is held for SCAN_DIV clock cycles. New words are
// double-buffered and committed only at the frame boundary, which keeps the
// display from tearing.
//
// Parameters
//   SCAN_DIV    clock cycles each digit is held (2 .. 2^20)
//
// Optional feature (compile-time macro)
//   SCAN_LZB_EN leading-zero blanking: digits 3..1 are blanked while they and
//               every higher nibble of the active word are zero
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   data_in     in   [15:0] display word, nibble i is digit i
//   load        in   single-cycle strobe, captures data_in into pending buffer
//   blank_mask  in   [3:0] bit i forces digit i blank (taken at each step)
//   digit       out  [3:0] code for the selected digit (4'hF = blank)
//   sel         out  [1:0] selected digit index (0 = rightmost anode)
//   frame_tick  out  one-cycle pulse in the first cycle of each frame
//   busy        out  a loaded word is waiting for the frame boundary
// -----------------------------------------------------------------------------
module display_scan_mux #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic [3:0]  blank_mask,
    output logic [3:0]  digit,
    output logic [1:0]  sel,
    output logic        frame_tick,
    output logic        busy
);

    localparam int unsigned   PW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] pcnt;
    logic [15:0]   active;
    logic [15:0]   pending;
    logic [15:0]   active_nxt;
    logic          tc;
    logic          fb;
    logic [1:0]    sel_nxt;
    logic [3:0]    lz_blank;
    logic [3:0]    code_nxt;

    always_comb begin
        tc      = (pcnt == PMAX);
        fb      = tc && (sel == 2'd3);
        sel_nxt = sel + 2'd1;

        // The word committed at the frame boundary is also the one the first
        // digit of the new frame is decoded from, so no stale digit appears.
        active_nxt = active;
        if (fb) begin
            if (load) begin
                active_nxt = data_in;
            end else if (busy) begin
                active_nxt = pending;
            end
        end

`ifdef SCAN_LZB_EN
        lz_blank[3] = (active_nxt[15:12] == 4'h0);
        lz_blank[2] = lz_blank[3] && (active_nxt[11:8] == 4'h0);
        lz_blank[1] = lz_blank[2] && (active_nxt[7:4] == 4'h0);
        lz_blank[0] = 1'b0;
`else
        lz_blank = 4'b0000;
`endif

        if (blank_mask[sel_nxt] || lz_blank[sel_nxt]) begin
            code_nxt = 4'hF;
        end else begin
            code_nxt = active_nxt[{sel_nxt, 2'b00} +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt       <= '0;
            sel        <= 2'd0;
            digit      <= 4'hF;
            frame_tick <= 1'b0;
            active     <= 16'hFFFF;
            pending    <= 16'h0000;
            busy       <= 1'b0;
        end else begin
            pcnt       <= tc ? '0 : pcnt + PW'(1);
            frame_tick <= fb;
            active     <= active_nxt;

            if (fb) begin
                busy <= 1'b0;
            end else if (load) begin
                pending <= data_in;
                busy    <= 1'b1;
            end

            // digit and sel move together so the decoder never sees a mixed pair
            if (tc) begin
                sel   <= sel_nxt;
                digit <= code_nxt;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
module tb_display_scan_mux;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic        load;
    logic [3:0]  blank_mask;
    logic [3:0]  digit;
    logic [1:0]  sel;
    logic        frame_tick;
    logic        busy;

    int pass_cnt = 0;
    int total    = 0;

    // reference model state
    int          t;
    logic [15:0] m_active;
    logic [15:0] m_pending;
    bit          m_busy;
    logic [1:0]  m_sel;
    logic [3:0]  m_digit;
    bit          m_ft;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mask;
        logic [15:0] exp;   // expected digit for sel s in nibble s
    } vec_t;

    vec_t vecs[5];

    display_scan_mux #(.SCAN_DIV(SD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .load       (load),
        .blank_mask (blank_mask),
        .digit      (digit),
        .sel        (sel),
        .frame_tick (frame_tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    function automatic logic [3:0] mcode(input int i, input logic [15:0] a, input logic [3:0] m);
        logic [15:0] upper;
        upper = a >> (4 * i);
        if (m[i]) return 4'hF;
`ifdef SCAN_LZB_EN
        if (i > 0 && upper == 16'h0) return 4'hF;
`endif
        return upper[3:0];
    endfunction

    task automatic model_reset();
        t         = 0;
        m_active  = 16'hFFFF;
        m_pending = 16'h0000;
        m_busy    = 0;
        m_sel     = 2'd0;
        m_digit   = 4'hF;
        m_ft      = 0;
    endtask

    // one clock: update model with inputs seen at this edge, then compare
    task automatic step();
        bit tcm, fbm;
        @(posedge clk);
        tcm = (t % SD) == SD - 1;
        fbm = (t % (4 * SD)) == 4 * SD - 1;
        if (fbm) begin
            if (load) begin
                m_active = data_in;
                m_busy   = 0;
            end else if (m_busy) begin
                m_active = m_pending;
                m_busy   = 0;
            end
        end else if (load) begin
            m_pending = data_in;
            m_busy    = 1;
        end
        m_ft = fbm;
        if (tcm) begin
            m_sel   = 2'(((t + 1) / SD) % 4);
            m_digit = mcode(int'(m_sel), m_active, blank_mask);
        end
        t++;
        #1;
        check("sel", int'(sel), int'(m_sel));
        check("digit", int'(digit), int'(m_digit));
        check("frame_tick", int'(frame_tick), int'(m_ft));
        check("busy", int'(busy), int'(m_busy));
    endtask

    task automatic advance_to(input int ph);
        for (int k = 0; k < 4 * SD * 2 && (t % (4 * SD)) != ph; k++) step();
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 16'h1234};
        vecs[1] = '{16'h9876, 4'b0101, 16'h9F7F};
`ifdef SCAN_LZB_EN
        vecs[2] = '{16'h0007, 4'b0000, 16'hFFF7};
        vecs[3] = '{16'h0000, 4'b0000, 16'hFFF0};
        vecs[4] = '{16'h0100, 4'b0000, 16'hF100};
`else
        vecs[2] = '{16'h0007, 4'b0000, 16'h0007};
        vecs[3] = '{16'h0000, 4'b0000, 16'h0000};
        vecs[4] = '{16'h0100, 4'b0000, 16'h0100};
`endif

        rst_n      = 1'b1;
        load       = 1'b0;
        data_in    = 16'h0;
        blank_mask = 4'h0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_digit", int'(digit), 15);
        check("rst_sel", int'(sel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_tick", int'(frame_tick), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // free-running scan: sel cadence and frame_tick period, all blank
        for (int k = 0; k < 40; k++) step();

        // table of words / masks, each observed over the frame after commit
        foreach (vecs[v]) begin
            advance_to(6);
            data_in    = vecs[v].data;
            blank_mask = vecs[v].mask;
            load       = 1'b1;
            step();
            load = 1'b0;
            check("vec_busy_after_load", int'(busy), 1);
            advance_to(0);
            check("vec_frame_tick", int'(frame_tick), 1);
            for (int s = 0; s < 4; s++) begin
                logic [15:0] e;
                e = vecs[v].exp;
                check("vec_sel", int'(sel), s);
                check("vec_digit", int'(digit), int'(e[4*s +: 4]));
                repeat (SD) step();
            end
        end

        // two loads in one frame: last one wins
        blank_mask = 4'h0;
        advance_to(3);
        data_in = 16'hAAAA; load = 1'b1; step(); load = 1'b0;
        advance_to(9);
        data_in = 16'h5B6C; load = 1'b1; step(); load = 1'b0;
        advance_to(0);
        check("dbl_digit0", int'(digit), 4'hC);
        repeat (SD) step();
        check("dbl_digit1", int'(digit), 4'h6);

        // load coincident with the frame boundary bypasses the pending buffer
        advance_to(15);
        data_in = 16'h0F0E; load = 1'b1; step(); load = 1'b0;
        check("fb_load_sel", int'(sel), 0);
        check("fb_load_digit", int'(digit), 4'hE);
        check("fb_load_busy", int'(busy), 0);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            load    = ($urandom_range(0, 7) == 0);
            data_in = ($urandom_range(0, 2) == 0) ? 16'($urandom & 32'h00FF) : 16'($urandom);
            if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom_range(0, 15));
            step();
            load = 1'b0;
        end

        // async reset at sel 2 with a word pending
        blank_mask = 4'h0;
        advance_to(9);
        data_in = 16'h4321; load = 1'b1; step(); load = 1'b0;
        check("mid_busy", int'(busy), 1);
        check("mid_sel", int'(sel), 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_digit", int'(digit), 15);
        check("async_sel", int'(sel), 0);
        check("async_busy", int'(busy), 0);
        check("async_frame_tick", int'(frame_tick), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) step();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
